// File: rtl/arb_pkg.sv
// Shared types and defaults for the L1-to-L2 miss arbiter.
// Zero latency (types only); no backpressure.
// Holds state/client enums and the default line and address widths.
package arb_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } client_t;

endpackage

// File: rtl/arb_grant.sv
// Winner select between the I-cache and D-cache; fixed D priority or round-robin (ARB_ROUND_ROBIN_EN).
// Purely combinational, zero latency.
// No backpressure; the result is only meaningful while at least one request is pending.
module arb_grant
    import arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  client_t last_grant,
`endif
    output client_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = CLIENT_I;
        if (i_req && d_req) begin
            grant = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        end else if (d_req) begin
            grant = CLIENT_D;
        end
    end
`else
    // With no request pending the answer is a don't-care, so D wins by default.
    always_comb begin
        grant = (d_req || !i_req) ? CLIENT_D : CLIENT_I;
    end
`endif

endmodule

// File: rtl/l1_l2_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one L2 port; round-robin when ARB_ROUND_ROBIN_EN is defined.
// L2 request registered 1 cycle after the request is sampled; resp is combinational from mem_resp.
// One transaction in flight; L1 requests are held until resp, with at least one idle cycle between grants.
module l1_l2_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    arb_state_t state, state_nxt;
    client_t    winner;
    logic       i_req, d_req;
    logic       load, clear;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    client_t last_grant;
`endif

    arb_grant u_grant (
        .i_req      (i_req),
        .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant      (winner)
    );

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    load      = 1'b1;
                    state_nxt = (winner == CLIENT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    i_resp    = 1'b1;
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    d_resp    = 1'b1;
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous read+write from the D-cache resolves to the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                if (winner == CLIENT_D) begin
                    mem_address <= d_address;
                    mem_wdata   <= d_wdata;
                    mem_write   <= d_write;
                    mem_read    <= ~d_write;
                end else begin
                    mem_address <= i_address;
                    mem_write   <= 1'b0;
                    mem_read    <= 1'b1;
                end
            end else if (clear) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= CLIENT_I;
        end else if (load) begin
            last_grant <= winner;
        end
    end
`endif

    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed, table-driven bench for l1_l2_arbiter with a hand-driven L2 response.
// Covers single transactions, contention, turnaround, reset mid-transaction and stray responses.
module tb_l1_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_l2_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           lat;
        logic [255:0] rdata;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                           input logic [255:0] wdata, input int lat,
                           input logic [255:0] rdata, input string tag);
        @(negedge clk);
        i_read    = !is_d;
        d_read    = is_d && !wr;
        d_write   = is_d && wr;
        i_address = is_d ? 32'h0 : addr;
        d_address = is_d ? addr : 32'h0;
        d_wdata   = wdata;
        @(negedge clk);
        #1;
        chk({tag, "_mem_read"}, mem_read, !(is_d && wr));
        chk({tag, "_mem_write"}, mem_write, is_d && wr);
        chk({tag, "_mem_address"}, mem_address, addr);
        if (is_d && wr) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            #1;
            chk({tag, "_wait_resp"}, {i_resp, d_resp}, 2'b00);
            chk({tag, "_hold_address"}, mem_address, addr);
        end
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        chk({tag, "_resp"}, {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
        chk({tag, "_rdata"}, is_d ? d_rdata : i_rdata, rdata);
        @(negedge clk);
        i_read   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        mem_resp = 1'b0;
        #1;
        chk({tag, "_done_rdwr"}, {mem_read, mem_write}, 2'b00);
        chk({tag, "_done_resp"}, {i_resp, d_resp}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [31:0] exp_addr;
        bit          exp_d;

        vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_1000, wdata: 256'h0,
                    lat: 5, rdata: {8{32'hDEAD_BEEF}}};
        vecs[1] = '{is_d: 1'b1, wr: 1'b1, addr: 32'h8000_0020, wdata: {32{8'hA5}},
                    lat: 3, rdata: 256'h0};
        vecs[2] = '{is_d: 1'b1, wr: 1'b0, addr: 32'h4000_0040, wdata: {32{8'h3C}},
                    lat: 1, rdata: {16{16'h1234}}};
        vecs[3] = '{is_d: 1'b0, wr: 1'b0, addr: 32'hFFFF_FFE0, wdata: 256'h0,
                    lat: 2, rdata: {4{64'h0123_4567_89AB_CDEF}}};

        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        chk("por_mem_read", mem_read, 1'b0);
        chk("por_mem_write", mem_write, 1'b0);
        chk("por_resp", {i_resp, d_resp}, 2'b00);
        do_reset();

        for (int v = 0; v < 4; v++) begin
            run_txn(vecs[v].is_d, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                    vecs[v].lat, vecs[v].rdata, $sformatf("vec%0d", v));
        end

        // Stray L2 response while idle must not produce a pulse or a transaction.
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = {8{32'hCAFE_F00D}};
        #1;
        chk("stray_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        #1;
        chk("stray_resp2", {i_resp, d_resp}, 2'b00);
        chk("stray_rdwr", {mem_read, mem_write}, 2'b00);
        mem_resp = 1'b0;
        run_txn(1'b0, 1'b0, 32'h0000_2000, 256'h0, 2, {8{32'h5555_AAAA}}, "post_stray");

        // Simultaneous reads: D first, one idle cycle, then I.
        do_reset();
        @(negedge clk);
        i_read    = 1'b1;
        i_address = 32'h0000_3000;
        d_read    = 1'b1;
        d_address = 32'h0000_4000;
        @(negedge clk);
        #1;
        chk("both_first_addr", mem_address, 32'h0000_4000);
        chk("both_first_read", mem_read, 1'b1);
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = {8{32'h1111_2222}};
        #1;
        chk("both_first_resp", {i_resp, d_resp}, 2'b01);
        @(negedge clk);
        d_read   = 1'b0;
        mem_resp = 1'b0;
        #1;
        chk("both_turnaround", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        #1;
        chk("both_second_addr", mem_address, 32'h0000_3000);
        chk("both_second_read", mem_read, 1'b1);
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = {8{32'h3333_4444}};
        #1;
        chk("both_second_resp", {i_resp, d_resp}, 2'b10);
        chk("both_second_rdata", i_rdata, {8{32'h3333_4444}});
        @(negedge clk);
        i_read   = 1'b0;
        mem_resp = 1'b0;

        // Both held across four transactions.
        do_reset();
        @(negedge clk);
        i_read    = 1'b1;
        i_address = 32'h0000_5000;
        d_read    = 1'b1;
        d_address = 32'h0000_6000;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (t % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            exp_addr = exp_d ? 32'h0000_6000 : 32'h0000_5000;
            @(negedge clk);
            #1;
            chk($sformatf("held%0d_addr", t), mem_address, exp_addr);
            @(negedge clk);
            mem_resp = 1'b1;
            #1;
            chk($sformatf("held%0d_resp", t), {i_resp, d_resp}, exp_d ? 2'b01 : 2'b10);
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            chk($sformatf("held%0d_gap", t), {mem_read, mem_write}, 2'b00);
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // Reset asserted mid-transaction clears the L2 request without a clock edge.
        @(negedge clk);
        d_write   = 1'b1;
        d_address = 32'h0000_7000;
        d_wdata   = {32{8'h5A}};
        @(negedge clk);
        #1;
        chk("mid_mem_write", mem_write, 1'b1);
        #2;
        rst      = 1'b1;
        mem_resp = 1'b1;
        #1;
        chk("mid_rst_rdwr", {mem_read, mem_write}, 2'b00);
        chk("mid_rst_address", mem_address, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 256'h0);
        chk("mid_rst_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        rst      = 1'b0;
        d_write  = 1'b0;
        mem_resp = 1'b0;
        run_txn(1'b0, 1'b0, 32'h0000_8000, 256'h0, 3, {8{32'h7777_8888}}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Arbitrates line-sized (256-bit) misses from the L1 instruction cache and L1 data cache onto the single L2 cache port.
- Sits directly upstream of the L2 cache and drives its mem_read/mem_write/mem_address/mem_wdata inputs.
- Consumes the L2 cache's mem_resp/mem_rdata and steers the response back to the granted L1.
- One transaction in flight at a time; the request is captured into registers on grant so that L2 inputs are glitch-free.

Parameters:
- ADDR_W, 32, byte address width shared by both L1s and the L2.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_read  input  1  I-cache line read request; held until i_resp.
- i_address  input  ADDR_W  I-cache line address.
- i_rdata  output  LINE_W  line returned to the I-cache.
- i_resp  output  1  one-cycle completion pulse to the I-cache.
- d_read  input  1  D-cache line read request; held until d_resp.
- d_write  input  1  D-cache line writeback request; held until d_resp.
- d_address  input  ADDR_W  D-cache line address.
- d_wdata  input  LINE_W  D-cache writeback line.
- d_rdata  output  LINE_W  line returned to the D-cache.
- d_resp  output  1  one-cycle completion pulse to the D-cache.
- mem_read  output  1  read request to L2 (registered).
- mem_write  output  1  write request to L2 (registered).
- mem_address  output  ADDR_W  registered address to L2.
- mem_wdata  output  LINE_W  registered write line to L2.
- mem_resp  input  1  L2 completion.
- mem_rdata  input  LINE_W  L2 read line.

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, last_grant=I. i_resp=d_resp=0 (combinational from state, therefore also 0).
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - If any request is pending, pick a winner, load the address/wdata/read/write registers, and go to SERVE_x at the next edge.
  - mem_read/mem_write rise exactly 1 cycle after the request is first sampled.
- SERVE_x:
  - Hold the registered L2 inputs stable.
  - When mem_resp=1, x_resp=1 in the same cycle (combinational) and the state returns to IDLE at the next edge, clearing mem_read/mem_write.
  - The other client's resp stays 0.
- i_rdata=d_rdata=mem_rdata at all times; only the resp pulse qualifies them.
- Turnaround: at least one IDLE cycle between transactions, so the L2 sees mem_read/mem_write low for at least 1 cycle between requests. Minimum cycles per transaction = L2 latency + 2.
- Default arbitration: D-cache has fixed priority over the I-cache whenever both are pending in IDLE.
- d_read and d_write both high: illegal. The write is issued (mem_write=1, mem_read=0) and a simulation assertion fires.
- Request dropped by an L1 before resp: illegal. The arbiter ignores it and completes the L2 transaction anyway, because the L2 cannot be aborted.
- mem_resp while IDLE: ignored, no resp pulse.
- Reset mid-transaction: outputs clear immediately. Reset is system-wide, so the L2 is reset simultaneously.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: when both clients are pending in IDLE, grant the client not recorded in last_grant. last_grant updates on every grant. A single pending client is always granted.
- ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority as above. last_grant is not implemented.

Decomposition:
- Package arb_pkg:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}.
  - client_t enum {CLIENT_I, CLIENT_D}.
  - Constants LINE_W_DEF=256 and ADDR_W_DEF=32.
- Sub-module arb_grant: combinational winner select from i_req, d_req, and last_grant, plus the round-robin ifdef. Output is a client_t.

Test Plan:
- I-only read: i_read=1, i_address=0x0000_1000; L2 responds after 5 cycles -> mem_read=1 and mem_address=0x1000 from cycle 1; i_resp pulses for 1 cycle with i_rdata=mem_rdata; d_resp=0 throughout.
- D writeback: d_write=1, d_address=0x8000_0020, d_wdata=all-0xA5 -> mem_write=1 and mem_wdata=all-0xA5 from cycle 1; d_resp 1-cycle pulse; mem_write=0 the next cycle.
- Simultaneous requests, macro off: i_read and d_read both high at cycle 0 -> D served first (mem_address=d_address), then after 1 IDLE cycle I served; total 2 resp pulses in order D, I.
- Simultaneous requests, ARB_ROUND_ROBIN_EN on: both held continuously for 4 transactions -> grants alternate D, I, D, I.
- Reset mid-transaction: assert rst during SERVE_D, with no clock edge needed -> mem_read=0, mem_write=0, state IDLE; a subsequent i_read is granted normally.
- Stray mem_resp in IDLE with no requests -> i_resp=d_resp=0 and the state is unchanged.
